// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - four-way intersection signal sequencer with emergency preemption
//
// Sequences the North-South (NS) and East-West (EW) approach heads through
// left arrow, green, yellow and all-red clearance. An emergency request steers
// the machine, through yellow and all-red where needed, into a hold that keeps
// green on the requested approach.
//
// Optional feature macro: PED_WALK_EN (pedestrian walk phase after all-red).
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset_n    in   1  asynchronous reset, active low
//   emerg_req  in   1  emergency vehicle present (level)
//   emerg_dir  in   1  approach to serve: 0=NS, 1=EW
//   ped_req    in   1  pedestrian request pulse/level (PED_WALK_EN only)
//   walk       out  1  pedestrian walk lamp (PED_WALK_EN only)
//   ns_out     out  4  NS lamps {left, green, yellow, red}
//   ew_out     out  4  EW lamps {left, green, yellow, red}
//   phase      out  4  current state code (debug)
//   preempt    out  1  emergency preemption in progress

module intersection_controller #(
  parameter int LEFT_CYC   = 5,
  parameter int GREEN_CYC  = 10,
  parameter int YEL_CYC    = 3,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       emerg_req,
  input  logic       emerg_dir,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic [3:0] phase,
  output logic       preempt
);

  typedef enum logic [3:0] {
    RST_RED = 4'd0,
    NS_LEFT = 4'd1,
    NS_GRN  = 4'd2,
    NS_YEL  = 4'd3,
    RED_A   = 4'd4,
    EW_LEFT = 4'd5,
    EW_GRN  = 4'd6,
    EW_YEL  = 4'd7,
    RED_B   = 4'd8,
    HOLD_NS = 4'd9,
`ifdef PED_WALK_EN
    HOLD_EW = 4'd10,
    WALK    = 4'd11
`else
    HOLD_EW = 4'd10
`endif
  } state_t;

  localparam logic [4:0] LEFT_END   = 5'(LEFT_CYC - 1);
  localparam logic [4:0] GREEN_END  = 5'(GREEN_CYC - 1);
  localparam logic [4:0] YEL_END    = 5'(YEL_CYC - 1);
  localparam logic [4:0] ALLRED_END = 5'(ALLRED_CYC - 1);
  localparam logic [4:0] WALK_END   = 5'(WALK_CYC - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       pre_q, pre_d;
  logic       pdir_q, pdir_d;    // last direction seen while emerg_req was high
  logic [4:0] last;
  logic       done;
  logic       act;               // emergency steering in effect this edge
  logic       tgt;               // approach the emergency wants served
  logic       in_hold;

`ifdef PED_WALK_EN
  logic       ped_pend_q;
  logic       walk_src_q, walk_src_d;  // 0: WALK entered from RED_A, 1: from RED_B
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_RED;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
      pdir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      pdir_q  <= pdir_d;
    end
  end

`ifdef PED_WALK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend_q <= 1'b0;
      walk_src_q <= 1'b0;
    end else begin
      walk_src_q <= walk_src_d;
      if (state_d == WALK && state_q != WALK)
        ped_pend_q <= 1'b0;
      else
        ped_pend_q <= ped_pend_q | ped_req;
    end
  end
`endif

  // Terminal count of the current timed state. WALK and the untimed HOLD
  // states share the default arm; HOLD never looks at it.
  always_comb begin
    case (state_q)
      NS_LEFT, EW_LEFT:       last = LEFT_END;
      NS_GRN, EW_GRN:         last = GREEN_END;
      NS_YEL, EW_YEL:         last = YEL_END;
      RST_RED, RED_A, RED_B:  last = ALLRED_END;
      default:                last = WALK_END;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pdir_d  = emerg_req ? emerg_dir : pdir_q;
    in_hold = (state_q == HOLD_NS) || (state_q == HOLD_EW);
    done    = (cnt_q == last);
    act     = emerg_req | pre_q;
    tgt     = emerg_req ? emerg_dir : pdir_q;
    // Once committed, a preemption runs through to HOLD; only leaving HOLD
    // without a request ends it.
    pre_d   = emerg_req | (pre_q & ~in_hold);
`ifdef PED_WALK_EN
    walk_src_d = walk_src_q;
`endif

    case (state_q)
      RST_RED: if (done) state_d = act ? (tgt ? HOLD_EW : HOLD_NS) : NS_LEFT;
      NS_LEFT: begin
        if (act)       state_d = tgt ? NS_YEL : HOLD_NS;
        else if (done) state_d = NS_GRN;
      end
      NS_GRN: begin
        if (act)       state_d = tgt ? NS_YEL : HOLD_NS;
        else if (done) state_d = NS_YEL;
      end
      NS_YEL: if (done) state_d = RED_A;
      RED_A: begin
        if (done) begin
          if (act) state_d = tgt ? HOLD_EW : HOLD_NS;
`ifdef PED_WALK_EN
          else if (ped_pend_q) begin
            state_d    = WALK;
            walk_src_d = 1'b0;
          end
`endif
          else state_d = EW_LEFT;
        end
      end
      EW_LEFT: begin
        if (act)       state_d = tgt ? HOLD_EW : EW_YEL;
        else if (done) state_d = EW_GRN;
      end
      EW_GRN: begin
        if (act)       state_d = tgt ? HOLD_EW : EW_YEL;
        else if (done) state_d = EW_YEL;
      end
      EW_YEL: if (done) state_d = RED_B;
      RED_B: begin
        if (done) begin
          if (act) state_d = tgt ? HOLD_EW : HOLD_NS;
`ifdef PED_WALK_EN
          else if (ped_pend_q) begin
            state_d    = WALK;
            walk_src_d = 1'b1;
          end
`endif
          else state_d = NS_LEFT;
        end
      end
      HOLD_NS: if (!emerg_req || emerg_dir)  state_d = NS_YEL;
      HOLD_EW: if (!emerg_req || !emerg_dir) state_d = EW_YEL;
`ifdef PED_WALK_EN
      WALK: begin
        // Abort back into the all-red we came from; it then hands off to HOLD.
        if (emerg_req) state_d = walk_src_q ? RED_B : RED_A;
        else if (done) state_d = walk_src_q ? NS_LEFT : EW_LEFT;
      end
`endif
      default: state_d = RST_RED;
    endcase

    // Every timed state exits at its terminal count, so the counter cannot wrap.
    if (state_d != state_q) cnt_d = '0;
    else if (in_hold)       cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 5'd1;
  end

  always_comb begin
    ns_out = 4'b0001;
    ew_out = 4'b0001;
    case (state_q)
      NS_LEFT:         ns_out = 4'b1001;
      NS_GRN, HOLD_NS: ns_out = 4'b0100;
      NS_YEL:          ns_out = 4'b0010;
      EW_LEFT:         ew_out = 4'b1001;
      EW_GRN, HOLD_EW: ew_out = 4'b0100;
      EW_YEL:          ew_out = 4'b0010;
      default: begin
        ns_out = 4'b0001;
        ew_out = 4'b0001;
      end
    endcase
    phase   = state_q;
    preempt = pre_q;
  end

`ifdef PED_WALK_EN
  assign walk = (state_q == WALK);
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// tb/tb_intersection_controller.sv - self-checking bench for intersection_controller

module tb_intersection_controller;

  localparam int LEFT_CYC   = 5;
  localparam int GREEN_CYC  = 10;
  localparam int YEL_CYC    = 3;
  localparam int ALLRED_CYC = 1;
  localparam int WALK_CYC   = 8;

  logic       clk;
  logic       reset_n;
  logic       emerg_req;
  logic       emerg_dir;
  logic [3:0] ns_out;
  logic [3:0] ew_out;
  logic [3:0] phase;
  logic       preempt;
`ifdef PED_WALK_EN
  logic       ped_req;
  logic       walk;
`endif

  int n_chk;
  int n_fail;
  bit model_on;

  intersection_controller #(
    .LEFT_CYC(LEFT_CYC), .GREEN_CYC(GREEN_CYC), .YEL_CYC(YEL_CYC),
    .ALLRED_CYC(ALLRED_CYC), .WALK_CYC(WALK_CYC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .emerg_req(emerg_req),
    .emerg_dir(emerg_dir),
`ifdef PED_WALK_EN
    .ped_req(ped_req),
    .walk(walk),
`endif
    .ns_out(ns_out),
    .ew_out(ew_out),
    .phase(phase),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Two approaches never show anything but red at the same time.
  always @(negedge clk) begin
    n_chk++;
    if (ns_out[3:1] != 3'b000 && ew_out[3:1] != 3'b000) begin
      n_fail++;
      $display("FAIL invariant: ns=%b ew=%b at %0t", ns_out, ew_out, $time);
    end
  end

  // ---------------- reference model ----------------
  // The intersection is described as "approach a is showing aspect asp with
  // rem cycles left". An all-red period belongs to the approach it follows.
  localparam int A_LEFT = 0, A_GRN = 1, A_YEL = 2, A_RED = 3, A_HOLD = 4;
  int m_a, m_asp, m_rem;
  bit m_pre, m_pd, m_rst;

  function automatic int dur(input int asp);
    case (asp)
      A_LEFT:  return LEFT_CYC;
      A_GRN:   return GREEN_CYC;
      A_YEL:   return YEL_CYC;
      A_RED:   return ALLRED_CYC;
      default: return 0;
    endcase
  endfunction

  task automatic model_go(input int a, input int asp);
    m_a = a; m_asp = asp; m_rem = dur(asp); m_rst = 0;
  endtask

  task automatic model_reset();
    // Power-up all-red behaves like the clearance after EW.
    m_a = 1; m_asp = A_RED; m_rem = ALLRED_CYC; m_rst = 1; m_pre = 0; m_pd = 0;
  endtask

  task automatic model_step(input bit r, input bit d);
    bit act;
    int tgt;
    bit was_hold;
    act = r | m_pre;
    tgt = r ? int'(d) : int'(m_pd);
    was_hold = (m_asp == A_HOLD);
    if (r) m_pd = d;
    m_pre = r | (m_pre & !was_hold);
    case (m_asp)
      A_HOLD: if (!r || int'(d) != m_a) model_go(m_a, A_YEL);
      A_LEFT, A_GRN: begin
        if (act) model_go(m_a, (tgt == m_a) ? A_HOLD : A_YEL);
        else if (m_rem == 1) model_go(m_a, m_asp + 1);
        else m_rem--;
      end
      A_YEL: if (m_rem == 1) model_go(m_a, A_RED); else m_rem--;
      default: begin
        if (m_rem == 1) begin
          if (act) model_go(tgt, A_HOLD);
          else model_go(1 - m_a, A_LEFT);
        end else m_rem--;
      end
    endcase
  endtask

  function automatic logic [3:0] lamp(input int asp);
    case (asp)
      A_LEFT:         return 4'b1001;
      A_GRN, A_HOLD:  return 4'b0100;
      A_YEL:          return 4'b0010;
      default:        return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] exp_phase();
    if (m_rst) return 4'd0;
    if (m_asp == A_HOLD) return 4'(9 + m_a);
    return 4'(1 + m_asp + 4 * m_a);
  endfunction

  task automatic model_check();
    logic [3:0] ens, eew;
    ens = (m_a == 0) ? lamp(m_asp) : 4'b0001;
    eew = (m_a == 1) ? lamp(m_asp) : 4'b0001;
    chk("mdl_ns", ns_out, ens);
    chk("mdl_ew", ew_out, eew);
    chk("mdl_preempt", preempt, m_pre);
    chk("mdl_phase", phase, exp_phase());
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit r, input bit d);
    emerg_req = r;
    emerg_dir = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    if (model_on) model_check();
  endtask

  task automatic do_reset();
    emerg_req = 1'b0;
    emerg_dir = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ns", ns_out, 4'b0001);
    chk("rst_ew", ew_out, 4'b0001);
    chk("rst_preempt", preempt, 1'b0);
    chk("rst_phase", phase, 4'd0);
`ifdef PED_WALK_EN
    chk("rst_walk", walk, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rst;
    int         n;
    bit         req;
    bit         dir;
    logic [3:0] ns;
    logic [3:0] ew;
    bit         pre;
    logic [3:0] ph;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input int n, input bit req, input bit dir,
                             input logic [3:0] ns, input logic [3:0] ew,
                             input bit pre, input logic [3:0] ph);
    vec_t t;
    t.rst = rst; t.n = n; t.req = req; t.dir = dir;
    t.ns = ns; t.ew = ew; t.pre = pre; t.ph = ph;
    return t;
  endfunction

  initial begin
    bit r, d;
    n_chk = 0;
    n_fail = 0;
    model_on = 1'b1;
    reset_n = 1'b0;
    emerg_req = 1'b0;
    emerg_dir = 1'b0;
`ifdef PED_WALK_EN
    ped_req = 1'b0;
`endif
    model_reset();

    // 1: free-running cycle, 38-cycle period
    tbl.push_back(v(1, 0, 0, 0, 4'b0001, 4'b0001, 0, 4'd0));
    tbl.push_back(v(0, 5, 0, 0, 4'b1001, 4'b0001, 0, 4'd1));
    tbl.push_back(v(0, 10, 0, 0, 4'b0100, 4'b0001, 0, 4'd2));
    tbl.push_back(v(0, 3, 0, 0, 4'b0010, 4'b0001, 0, 4'd3));
    tbl.push_back(v(0, 1, 0, 0, 4'b0001, 4'b0001, 0, 4'd4));
    tbl.push_back(v(0, 5, 0, 0, 4'b0001, 4'b1001, 0, 4'd5));
    tbl.push_back(v(0, 10, 0, 0, 4'b0001, 4'b0100, 0, 4'd6));
    tbl.push_back(v(0, 3, 0, 0, 4'b0001, 4'b0010, 0, 4'd7));
    tbl.push_back(v(0, 1, 0, 0, 4'b0001, 4'b0001, 0, 4'd8));
    tbl.push_back(v(0, 5, 0, 0, 4'b1001, 4'b0001, 0, 4'd1));
    // 2: EW emergency 3 cycles into NS green
    tbl.push_back(v(1, 0, 0, 0, 4'b0001, 4'b0001, 0, 4'd0));
    tbl.push_back(v(0, 5, 0, 0, 4'b1001, 4'b0001, 0, 4'd1));
    tbl.push_back(v(0, 3, 0, 0, 4'b0100, 4'b0001, 0, 4'd2));
    tbl.push_back(v(0, 3, 1, 1, 4'b0010, 4'b0001, 1, 4'd3));
    tbl.push_back(v(0, 1, 1, 1, 4'b0001, 4'b0001, 1, 4'd4));
    tbl.push_back(v(0, 4, 1, 1, 4'b0001, 4'b0100, 1, 4'd10));
    tbl.push_back(v(0, 3, 0, 1, 4'b0001, 4'b0010, 0, 4'd7));
    tbl.push_back(v(0, 1, 0, 1, 4'b0001, 4'b0001, 0, 4'd8));
    tbl.push_back(v(0, 1, 0, 0, 4'b1001, 4'b0001, 0, 4'd1));
    // 3: NS emergency at NS_LEFT count 2
    tbl.push_back(v(1, 0, 0, 0, 4'b0001, 4'b0001, 0, 4'd0));
    tbl.push_back(v(0, 3, 0, 0, 4'b1001, 4'b0001, 0, 4'd1));
    tbl.push_back(v(0, 4, 1, 0, 4'b0100, 4'b0001, 1, 4'd9));
    tbl.push_back(v(0, 3, 0, 0, 4'b0010, 4'b0001, 0, 4'd3));
    tbl.push_back(v(0, 1, 0, 0, 4'b0001, 4'b0001, 0, 4'd4));
    tbl.push_back(v(0, 1, 0, 0, 4'b0001, 4'b1001, 0, 4'd5));
    // 4: direction flip during HOLD_NS, emergency from the reset all-red
    tbl.push_back(v(1, 0, 0, 0, 4'b0001, 4'b0001, 0, 4'd0));
    tbl.push_back(v(0, 4, 1, 0, 4'b0100, 4'b0001, 1, 4'd9));
    tbl.push_back(v(0, 3, 1, 1, 4'b0010, 4'b0001, 1, 4'd3));
    tbl.push_back(v(0, 1, 1, 1, 4'b0001, 4'b0001, 1, 4'd4));
    tbl.push_back(v(0, 3, 1, 1, 4'b0001, 4'b0100, 1, 4'd10));
    tbl.push_back(v(0, 3, 0, 1, 4'b0001, 4'b0010, 0, 4'd7));

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else begin
        for (int k = 0; k < tbl[i].n; k++) begin
          step(tbl[i].req, tbl[i].dir);
          chk($sformatf("tbl%0d_ns", i), ns_out, tbl[i].ns);
          chk($sformatf("tbl%0d_ew", i), ew_out, tbl[i].ew);
          chk($sformatf("tbl%0d_preempt", i), preempt, tbl[i].pre);
          chk($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
        end
      end
    end

    // 5: asynchronous reset mid EW_YEL and mid HOLD
    do_reset();
    for (int k = 0; k < 35; k++) step(0, 0);
    chk("pre_rst_ew_yel", ew_out, 4'b0010);
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 1);
    chk("pre_rst_hold", preempt, 1'b1);
    do_reset();

`ifdef PED_WALK_EN
    // 6: pedestrian walk after RED_A, then an emergency abort
    model_on = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int k = 0; k < 19; k++) begin
        ped_req = (k == 7);
        step(0, 0);
      end
      ped_req = 1'b0;
      if (pass == 0) begin
        for (int k = 0; k < WALK_CYC; k++) begin
          step(0, 0);
          chk("walk_on", walk, 1'b1);
          chk("walk_ns", ns_out, 4'b0001);
          chk("walk_ew", ew_out, 4'b0001);
        end
        step(0, 0);
        chk("walk_done", walk, 1'b0);
        chk("walk_ew_left", ew_out, 4'b1001);
      end else begin
        step(0, 0);
        step(0, 0);
        chk("walk_mid", walk, 1'b1);
        step(1, 1);
        chk("abort_walk", walk, 1'b0);
        chk("abort_phase", phase, 4'd4);
        chk("abort_preempt", preempt, 1'b1);
        step(1, 1);
        chk("abort_hold_ew", ew_out, 4'b0100);
      end
    end
    model_on = 1'b1;
    do_reset();
`endif

    // Random emergency traffic against the model, with occasional resets.
    r = 0;
    d = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 24) == 0) r = ~r;
      if ($urandom_range(0, 19) == 0) d = ~d;
      if ($urandom_range(0, 799) == 0) do_reset();
      else step(r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
